// File: rtl/principal.sv
// principal: seven-key tone generator; lowest pressed key selects a note whose
// half-period is derived from CLK_FREQ_HZ, output is a registered 50% square wave.
module principal #(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int CNT_W       = 21
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] teclas,
  output logic       clk_out
);
  // frequencies are given in centi-hertz; result is round(CLK / (2*f))
  function automatic logic [CNT_W-1:0] half(input longint fc);
    return CNT_W'((longint'(CLK_FREQ_HZ) * 100 + fc) / (2 * fc));
  endfunction
  localparam logic [CNT_W-1:0] H_DO  = half(26163);
  localparam logic [CNT_W-1:0] H_RE  = half(29366);
  localparam logic [CNT_W-1:0] H_MI  = half(32963);
  localparam logic [CNT_W-1:0] H_FA  = half(34923);
  localparam logic [CNT_W-1:0] H_SOL = half(39200);
  localparam logic [CNT_W-1:0] H_LA  = half(44000);
  localparam logic [CNT_W-1:0] H_SI  = half(49388);
  logic [6:0]       r_sync1, r_sync2;
  logic [2:0]       r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out;
  logic [2:0]       w_idx;
  logic [CNT_W-1:0] w_half;
  // index 0 means silence, 1..7 are Do..Si
  always_comb begin
    w_idx = r_sync2[0] ? 3'd1 : r_sync2[1] ? 3'd2 : r_sync2[2] ? 3'd3 :
            r_sync2[3] ? 3'd4 : r_sync2[4] ? 3'd5 : r_sync2[5] ? 3'd6 :
            r_sync2[6] ? 3'd7 : 3'd0;
    w_half = w_idx == 3'd1 ? H_DO  : w_idx == 3'd2 ? H_RE : w_idx == 3'd3 ? H_MI :
             w_idx == 3'd4 ? H_FA  : w_idx == 3'd5 ? H_SOL : w_idx == 3'd6 ? H_LA :
             H_SI;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_out   <= 1'b0;
    end else begin
      r_sync1 <= teclas;
      r_sync2 <= r_sync1;
      r_idx   <= w_idx;
      if (w_idx != r_idx || w_idx == 3'd0) begin
        r_cnt <= '0;
        r_out <= 1'b0;
      end else if (r_cnt == w_half - CNT_W'(1)) begin
        r_cnt <= '0;
        r_out <= ~r_out;
      end else
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end
  assign clk_out = r_out;
endmodule

// File: tb/tb_principal.sv
// tb_principal: directed and random key sequences checked cycle by cycle against
// a timing model of the tone generator, plus explicit period/latency measurements.
module tb_principal;
  localparam int CLK_HZ = 100000;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] teclas = '0;
  logic       clk_out;
  int checks = 0;
  int failures = 0;
  real freqs [7] = '{261.63, 293.66, 329.63, 349.23, 392.00, 440.00, 493.88};
  int  halfp [7];
  logic [6:0] q0 = '0, q1 = '0;
  int prev = 0, start = 0, cyc = 0;
  logic exp_out = 1'b0;

  principal #(.CLK_FREQ_HZ(CLK_HZ), .CNT_W(21)) dut (
    .clk(clk), .reset(reset), .teclas(teclas), .clk_out(clk_out));

  always #5 clk = ~clk;

  function automatic int sel(input logic [6:0] k);
    for (int i = 0; i < 7; i++) if (k[i]) return i + 1;
    return 0;
  endfunction

  task automatic check(input string tag, input int got, input int want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, want);
    end
  endtask

  task automatic step(input logic [6:0] k, input logic r);
    int cur;
    @(negedge clk);
    teclas = k;
    reset = r;
    @(posedge clk);
    cur = sel(q1);
    if (r) begin
      q0 = '0; q1 = '0; prev = 0; exp_out = 1'b0; start = cyc;
    end else begin
      q1 = q0; q0 = k;
      if (cur != prev || cur == 0) begin
        exp_out = 1'b0; start = cyc;
      end else
        exp_out = (((cyc - start) / halfp[cur-1]) % 2) == 1;
      prev = cur;
    end
    cyc++;
    #1;
    checks++;
    assert (clk_out === exp_out) else begin
      failures++;
      $error("FAIL clk_out cyc=%0d got=%b exp=%b", cyc, clk_out, exp_out);
    end
  endtask

  task automatic hold(input logic [6:0] k, input int n);
    for (int i = 0; i < n; i++) step(k, 1'b0);
  endtask

  initial begin
    int n;
    logic [6:0] k;
    for (int i = 0; i < 7; i++) halfp[i] = $rtoi(CLK_HZ / (2.0 * freqs[i]) + 0.5);
    repeat (3) step(7'b0, 1'b1);
    check("reset_out", clk_out, 0);
    // Do held: first rise exactly 3+HALF cycles after reset release
    n = 0;
    do begin step(7'b0000001, 1'b0); n++; end while (clk_out !== 1'b1 && n < 1000);
    check("do_first_rise", n, 3 + halfp[0]);
    hold(7'b0000001, 4 * halfp[0]);
    // all keys -> Do, then drop bit0 -> Re restarts low
    hold(7'b1111111, 500);
    step(7'b1111110, 1'b0);
    hold(7'b1111110, 2);
    check("re_restart_low", clk_out, 0);
    hold(7'b1111110, 4 * halfp[1]);
    hold(7'b0000000, 3);
    check("silence_low", clk_out, 0);
    hold(7'b0000000, 400);
    // each note alone, then measure its high time directly
    for (int b = 0; b < 7; b++) begin
      hold(7'(1 << b), 10);
      n = 0;
      do begin step(7'(1 << b), 1'b0); n++; end while (clk_out !== 1'b1 && n < 1000);
      n = 0;
      do begin step(7'(1 << b), 1'b0); n++; end while (clk_out === 1'b1 && n < 1000);
      check("high_time", n, halfp[b]);
      n = 0;
      do begin step(7'(1 << b), 1'b0); n++; end while (clk_out !== 1'b1 && n < 1000);
      check("low_time", n, halfp[b]);
    end
    // reset pulse while Mi is high
    hold(7'b0000000, 5);
    n = 0;
    do begin step(7'b0000100, 1'b0); n++; end while (!exp_out && n < 1000);
    check("mi_high_before_reset", clk_out, 1);
    step(7'b0000100, 1'b1);
    check("reset_mid_tone", clk_out, 0);
    n = 0;
    do begin step(7'b0000100, 1'b0); n++; end while (clk_out !== 1'b1 && n < 1000);
    check("mi_restart_rise", n, 3 + halfp[2]);
    // one-cycle glitch of a higher-priority key must not produce an edge
    hold(7'b0000000, 5);
    step(7'b0000001, 1'b0);
    hold(7'b0000000, 400);
    check("glitch_silent", clk_out, 0);
    // random key activity including one-cycle glitches
    k = '0;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 199) == 0) k = 7'($urandom);
      if ($urandom_range(0, 299) == 0) k = '0;
      if ($urandom_range(0, 499) == 0) step(7'($urandom), 1'b0);
      else step(k, $urandom_range(0, 2999) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
